// File: rtl/subleq_pkg.sv
// Purpose: shared types and widths for the subleq memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ADDR_W/DATA_W defaults, owner_t (request owner tag), mem_cmd_t
// (registered memory command).
package subleq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/subleq_rr_pick.sv
// Purpose: 2-way grant picker (core/host) with round-robin pointer and lock gating.
// Latency: grants are combinational from req/lock; pointer updates on the transfer edge.
// Backpressure: the loser's gnt stays low, so it holds its request until granted.
// Ports: clock, reset_n (sync, active-low); c_req/h_req requests; lock forces
// core-only grants; c_gnt/h_gnt one-hot-or-zero grants.
// Build option SUBLEQ_ARB_HOST_PRIORITY_EN: host wins every contended cycle and
// no pointer register exists.
module subleq_rr_pick
  import subleq_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic c_req,
  input  logic h_req,
  input  logic lock,
  output logic c_gnt,
  output logic h_gnt
);

`ifdef SUBLEQ_ARB_HOST_PRIORITY_EN

  // Fixed priority has no state; clock/reset are kept for a uniform port list.
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset_n;

  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (lock) begin
      c_gnt = c_req;
    end else if (h_req) begin
      h_gnt = 1'b1;
    end else begin
      c_gnt = c_req;
    end
  end

`else

  // prefer names the requester that wins the next contended cycle.
  owner_t prefer;

  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (lock) begin
      c_gnt = c_req;
    end else if (c_req && h_req) begin
      c_gnt = (prefer == OWNER_CORE);
      h_gnt = (prefer == OWNER_HOST);
    end else begin
      c_gnt = c_req;
      h_gnt = h_req;
    end
  end

  // gnt implies req, so a grant here is an actual transfer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prefer <= OWNER_CORE;
    end else if (c_gnt) begin
      prefer <= OWNER_HOST;
    end else if (h_gnt) begin
      prefer <= OWNER_CORE;
    end
  end

`endif

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Purpose: shares the single-port subleq memory between the core (C) and host (H).
// Latency: command on mem_* one cycle after transfer; read return one cycle later.
// Backpressure: combinational gnt; requester holds req/we/addr/wdata until gnt.
// Ports: clock, reset_n (sync, active-low); c_* core request/lock/grant/return;
// h_* host request/grant/return; mem_* registered memory command, mem_rdata
// synchronous read data. Build option SUBLEQ_ARB_HOST_PRIORITY_EN selects host
// priority instead of round-robin (see subleq_rr_pick).
// ADDR_W/DATA_W must match the subleq_pkg widths used by mem_cmd_t.
module subleq_mem_arbiter #(
  parameter int ADDR_W = subleq_pkg::ADDR_W,
  parameter int DATA_W = subleq_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import subleq_pkg::mem_cmd_t;
  import subleq_pkg::owner_t;
  import subleq_pkg::OWNER_CORE;
  import subleq_pkg::OWNER_HOST;

  logic              lock_q;
  mem_cmd_t          cmd_q;
  // Stage 1 tag travels alongside cmd_q; stage 2 is the rvalid cycle.
  logic              rd1_q;
  owner_t            own1_q;
  logic              c_rvalid_q;
  logic              h_rvalid_q;
  logic [DATA_W-1:0] c_hold_q;
  logic [DATA_W-1:0] h_hold_q;

  subleq_rr_pick u_pick (
    .clock   (clock),
    .reset_n (reset_n),
    .c_req   (c_req),
    .h_req   (h_req),
    .lock    (lock_q),
    .c_gnt   (c_gnt),
    .h_gnt   (h_gnt)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      cmd_q      <= '0;
      rd1_q      <= 1'b0;
      own1_q     <= OWNER_CORE;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_hold_q   <= '0;
      h_hold_q   <= '0;
    end else begin
      // Lock arms on a locked core transfer and drops as soon as c_lock falls.
      if (c_gnt && c_lock) begin
        lock_q <= 1'b1;
      end else if (!c_lock) begin
        lock_q <= 1'b0;
      end

      if (c_gnt) begin
        cmd_q.en    <= 1'b1;
        cmd_q.we    <= c_we;
        cmd_q.addr  <= c_addr;
        cmd_q.wdata <= c_wdata;
      end else if (h_gnt) begin
        cmd_q.en    <= 1'b1;
        cmd_q.we    <= h_we;
        cmd_q.addr  <= h_addr;
        cmd_q.wdata <= h_wdata;
      end else begin
        cmd_q.en <= 1'b0;
        cmd_q.we <= 1'b0;
      end

      rd1_q  <= (c_gnt && !c_we) || (h_gnt && !h_we);
      own1_q <= h_gnt ? OWNER_HOST : OWNER_CORE;

      c_rvalid_q <= rd1_q && (own1_q == OWNER_CORE);
      h_rvalid_q <= rd1_q && (own1_q == OWNER_HOST);

      // Keep the last returned byte visible after rvalid drops.
      if (c_rvalid_q) c_hold_q <= mem_rdata;
      if (h_rvalid_q) h_hold_q <= mem_rdata;
    end
  end

  assign mem_en    = cmd_q.en;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Memory data arrives in the rvalid cycle itself, so it is passed straight through.
  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign c_rdata  = c_rvalid_q ? mem_rdata : c_hold_q;
  assign h_rdata  = h_rvalid_q ? mem_rdata : h_hold_q;

endmodule
